// File: rtl/riscv_tb_pkg.sv
// Shared types and helpers for the commit monitor.
// Monitor state encoding and signature rotate.
package riscv_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } mon_state_e;

  // Rotate left by one within the low w bits.
  // v must be zero-extended above bit w-1;
  // the caller truncates back to w bits.
  function automatic logic [63:0] rotl1(
    input logic [63:0] v,
    input int unsigned w
  );
    return (v << 1) | (v >> (w - 1));
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead synchronous FIFO with sync clear.
// Ports: wr_en/wdata push, rd_en/rdata pop, full/empty/count.
module trace_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign rdata = mem[rp_q];

  // Full implies non-empty, so a pop frees the slot.
  assign pop  = !clr && rd_en && !empty;
  assign push = !clr && wr_en && (!full || pop);

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (clr) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = wp_q + 1'b1;
      if (pop)  rp_d = rp_q + 1'b1;
      unique case (1'b1)
        push && !pop: cnt_d = cnt_q + 1'b1;
        pop && !push: cnt_d = cnt_q - 1'b1;
        default:      cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= wdata;
  end

endmodule

// File: rtl/riscv_commit_monitor.sv
// Commit-stream monitor: trace FIFO, signature, halt/timeout.
// Ports: cm_* commit in, rd_* drain, status/counters out.
module riscv_commit_monitor
  import riscv_tb_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 16,
  parameter int TIMEOUT     = 1024,
  parameter int HALT_REPEAT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     cm_valid,
  input  logic [XLEN-1:0]          cm_pc,
  input  logic [XLEN-1:0]          cm_result,
  input  logic [XLEN-1:0]          exp_sig,
  input  logic                     rd_en,
  output logic [XLEN-1:0]          rd_pc,
  output logic [XLEN-1:0]          rd_result,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [XLEN-1:0]          signature,
  output logic [31:0]              cycle_cnt,
  output logic [31:0]              commit_cnt,
  output logic [1:0]               state,
  output logic                     done,
  output logic                     pass
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  localparam logic [31:0] HR      = 32'(HALT_REPEAT);

  mon_state_e      state_q, state_d;
  logic [XLEN-1:0] sig_q, sig_d;
  logic [31:0]     cyc_q, cyc_d;
  logic [31:0]     cmt_q, cmt_d;
  logic            ovf_q, ovf_d;
  logic [31:0]     rep_q, rep_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic            lpv_q, lpv_d;

  logic            commit;
  logic            f_full;
  logic [2*XLEN-1:0] f_rdata;

  assign commit = !start && (state_q == ST_RUN) && cm_valid;

  trace_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .wr_en (commit),
    .wdata ({cm_pc, cm_result}),
    .rd_en (rd_en),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_d   = state_q;
    sig_d     = sig_q;
    cyc_d     = cyc_q;
    cmt_d     = cmt_q;
    ovf_d     = ovf_q;
    rep_d     = rep_q;
    last_pc_d = last_pc_q;
    lpv_d     = lpv_q;
    if (start) begin
      state_d   = ST_RUN;
      sig_d     = '0;
      cyc_d     = '0;
      cmt_d     = '0;
      ovf_d     = 1'b0;
      rep_d     = '0;
      last_pc_d = '0;
      lpv_d     = 1'b0;
    end else if (state_q == ST_RUN) begin
      // Counter holds on the timeout edge.
      if (cyc_q != TO_LAST && cyc_q != '1)
        cyc_d = cyc_q + 1'b1;
      if (cm_valid) begin
        cmt_d = cmt_q + 1'b1;
        sig_d = XLEN'(rotl1(64'(sig_q), XLEN))
              ^ cm_pc ^ cm_result;
        rep_d = (lpv_q && cm_pc == last_pc_q)
              ? rep_q + 1'b1 : 32'd1;
        last_pc_d = cm_pc;
        lpv_d     = 1'b1;
        if (f_full && !rd_en) ovf_d = 1'b1;
      end
      unique case (1'b1)
        cm_valid && rep_d == HR: state_d = ST_HALTED;
        cyc_q == TO_LAST:        state_d = ST_TIMEOUT;
        default:                 state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sig_q     <= '0;
      cyc_q     <= '0;
      cmt_q     <= '0;
      ovf_q     <= 1'b0;
      rep_q     <= '0;
      last_pc_q <= '0;
      lpv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_d;
      cyc_q     <= cyc_d;
      cmt_q     <= cmt_d;
      ovf_q     <= ovf_d;
      rep_q     <= rep_d;
      last_pc_q <= last_pc_d;
      lpv_q     <= lpv_d;
    end
  end

  assign rd_pc      = f_rdata[2*XLEN-1:XLEN];
  assign rd_result  = f_rdata[XLEN-1:0];
  assign overflow   = ovf_q;
  assign signature  = sig_q;
  assign cycle_cnt  = cyc_q;
  assign commit_cnt = cmt_q;
  assign state      = state_q;
  assign done       = (state_q == ST_HALTED)
                   || (state_q == ST_TIMEOUT);
  assign pass       = (state_q == ST_HALTED)
                   && (sig_q == exp_sig);

endmodule

// File: tb/tb_riscv_commit_monitor.sv
// Self-checking bench for riscv_commit_monitor.
// Table vectors, directed corners and random vs a queue model.
module tb_riscv_commit_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cm_valid = 1'b0;
  logic [31:0] cm_pc = '0;
  logic [31:0] cm_result = '0;
  logic [31:0] exp_sig = '0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_pc, rd_result;
  logic        empty, overflow, done, pass;
  logic [4:0]  count;
  logic [31:0] signature, cycle_cnt, commit_cnt;
  logic [1:0]  state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  riscv_commit_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cm_valid(cm_valid), .cm_pc(cm_pc),
    .cm_result(cm_result), .exp_sig(exp_sig),
    .rd_en(rd_en), .rd_pc(rd_pc),
    .rd_result(rd_result), .empty(empty),
    .count(count), .overflow(overflow),
    .signature(signature), .cycle_cnt(cycle_cnt),
    .commit_cnt(commit_cnt), .state(state),
    .done(done), .pass(pass)
  );

  // Reference model: states 0 idle,1 run,2 halted,3 timeout.
  int          m_state;
  logic [31:0] m_sig;
  int unsigned m_cyc, m_cmt;
  bit          m_ovf;
  logic [31:0] m_last;
  bit          m_lpv;
  int          m_rep;
  logic [31:0] q_pc[$];
  logic [31:0] q_res[$];

  function automatic logic [31:0] rl(input logic [31:0] x);
    return (x << 1) | (x >> 31);
  endfunction

  task automatic model_clear(input int st);
    m_state = st; m_sig = 0; m_cyc = 0; m_cmt = 0;
    m_ovf = 0; m_last = 0; m_lpv = 0; m_rep = 0;
    q_pc.delete(); q_res.delete();
  endtask

  task automatic model_step();
    bit halt;
    if (start) begin
      model_clear(1);
      return;
    end
    if (rd_en && q_pc.size() > 0) begin
      void'(q_pc.pop_front());
      void'(q_res.pop_front());
    end
    if (m_state != 1) return;
    halt = 0;
    if (cm_valid) begin
      m_cmt++;
      m_sig = rl(m_sig) ^ cm_pc ^ cm_result;
      if (m_lpv && cm_pc == m_last) m_rep++;
      else m_rep = 1;
      m_last = cm_pc; m_lpv = 1;
      if (m_rep == 4) halt = 1;
      if (q_pc.size() < 16) begin
        q_pc.push_back(cm_pc);
        q_res.push_back(cm_result);
      end else m_ovf = 1;
    end
    if (halt) m_state = 2;
    else if (m_cyc == 1023) m_state = 3;
    if (m_cyc < 1023) m_cyc++;
  endtask

  function automatic void chk(
    input string nm, input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endfunction

  task automatic compare_all();
    chk("state", 64'(state), 64'(m_state));
    chk("done", 64'(done), 64'(m_state >= 2));
    chk("pass", 64'(pass),
        64'(m_state == 2 && m_sig == exp_sig));
    chk("count", 64'(count), 64'(q_pc.size()));
    chk("empty", 64'(empty), 64'(q_pc.size() == 0));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("signature", 64'(signature), 64'(m_sig));
    chk("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
    chk("commit_cnt", 64'(commit_cnt), 64'(m_cmt));
    if (q_pc.size() > 0) begin
      chk("rd_pc", 64'(rd_pc), 64'(q_pc[0]));
      chk("rd_result", 64'(rd_result), 64'(q_res[0]));
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(
    input bit s, input bit v, input logic [31:0] pc,
    input logic [31:0] res, input bit rd
  );
    start = s; cm_valid = v; cm_pc = pc;
    cm_result = res; rd_en = rd;
    step();
    start = 0; cm_valid = 0; rd_en = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear(0);
    compare_all();
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    bit          st, v, rd;
    logic [31:0] pc, res;
    int          e_cnt;
    logic [31:0] e_sig;
    int          e_cmt;
    logic [31:0] e_hpc, e_hres;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1,0,0, 0, 0, 0, 32'h00, 0, 0, 0};
    tbl[1]  = '{0,1,0, 0, 5, 1, 32'h05, 1, 0, 5};
    tbl[2]  = '{0,1,0, 4, 7, 2, 32'h09, 2, 0, 5};
    tbl[3]  = '{0,1,0, 8,12, 3, 32'h16, 3, 0, 5};
    tbl[4]  = '{0,0,1, 0, 0, 2, 32'h16, 3, 4, 7};
    tbl[5]  = '{0,0,1, 0, 0, 1, 32'h16, 3, 8,12};
    tbl[6]  = '{0,0,1, 0, 0, 0, 32'h16, 3, 0, 0};
    tbl[7]  = '{0,0,1, 0, 0, 0, 32'h16, 3, 0, 0};
    tbl[8]  = '{1,0,0, 0, 0, 0, 32'h00, 0, 0, 0};
    tbl[9]  = '{0,1,0, 4, 1, 1, 32'h05, 1, 4, 1};
    tbl[10] = '{0,1,0, 8, 2, 2, 32'h00, 2, 4, 1};

    model_clear(0);
    #12;
    compare_all();
    chk("reset_state", 64'(state), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors: ordering and signature.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].st, tbl[i].v, tbl[i].pc,
            tbl[i].res, tbl[i].rd);
      chk($sformatf("tbl%0d_count", i),
          64'(count), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_sig", i),
          64'(signature), 64'(tbl[i].e_sig));
      chk($sformatf("tbl%0d_cmt", i),
          64'(commit_cnt), 64'(tbl[i].e_cmt));
      if (tbl[i].e_cnt > 0) begin
        chk($sformatf("tbl%0d_hpc", i),
            64'(rd_pc), 64'(tbl[i].e_hpc));
        chk($sformatf("tbl%0d_hres", i),
            64'(rd_result), 64'(tbl[i].e_hres));
      end
    end

    // Halt after four commits at the same pc.
    drive(1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      chk("halt_pre_state", 64'(state), 64'd1);
      drive(0, 1, 32'h10, 32'(i), 0);
    end
    chk("halt_state", 64'(state), 64'd2);
    chk("halt_sig", 64'(signature), 64'hF2);
    chk("halt_done", 64'(done), 64'd1);
    exp_sig = 32'hF2; #1;
    chk("halt_pass", 64'(pass), 64'd1);
    exp_sig = 32'h0; #1;
    chk("halt_nopass", 64'(pass), 64'd0);
    drive(0, 1, 32'h20, 32'h1, 0);
    chk("halt_frozen_cmt", 64'(commit_cnt), 64'd4);

    // Timeout after exactly 1024 RUN cycles.
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 1023; i++) step();
    chk("to_pre_state", 64'(state), 64'd1);
    step();
    chk("to_state", 64'(state), 64'd3);
    chk("to_cyc", 64'(cycle_cnt), 64'd1023);
    chk("to_pass", 64'(pass), 64'd0);
    step();
    chk("to_cyc_frozen", 64'(cycle_cnt), 64'd1023);

    // Overflow with and without a same-cycle pop.
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++)
      drive(0, 1, 32'(i * 4), 32'(i), 0);
    chk("ovf_count", 64'(count), 64'd16);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_cmt", 64'(commit_cnt), 64'd17);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      drive(0, 1, 32'(i * 4), 32'(i), 0);
    drive(0, 1, 32'h100, 32'h55, 1);
    chk("popwr_count", 64'(count), 64'd16);
    chk("popwr_ovf", 64'(overflow), 64'd0);
    chk("popwr_head", 64'(rd_pc), 64'd4);

    // Reset mid-run, then a fresh run.
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      drive(0, 1, 32'(i * 4), 32'(i + 3), 0);
    do_reset();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_cmt", 64'(commit_cnt), 64'd0);
    chk("rst_cyc", 64'(cycle_cnt), 64'd0);
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 32'h40, 32'h2, 0);
    chk("fresh_cmt", 64'(commit_cnt), 64'd1);
    chk("fresh_state", 64'(state), 64'd1);

    // Random traffic against the model.
    for (int r = 0; r < 6; r++) begin
      drive(1, 0, 0, 0, 0);
      for (int c = 0; c < 400; c++) begin
        start    = ($urandom_range(0, 99) == 0);
        cm_valid = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 2) == 0) cm_pc = m_last;
        else cm_pc = 32'(4 * $urandom_range(0, 7));
        cm_result = $urandom;
        rd_en    = ($urandom_range(0, 9) < 3);
        if ($urandom_range(0, 1) == 1) exp_sig = m_sig;
        else exp_sig = $urandom;
        step();
      end
      start = 0; cm_valid = 0; rd_en = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_commit_monitor.md
Name: riscv_commit_monitor

Overview:
- Synthesizable commit-stream monitor/checker for riscv_top; replaces free-running printouts with hardware observation.
- Captures committed (pc, result) pairs into a parametrised trace FIFO, folds them into a running signature, counts cycles/commits, detects program halt (self-loop) and timeout.
- Sits beside the core in the testbench top; drains via a show-ahead read port.

Parameters:
- XLEN, 32, width of pc/result/signature.
- DEPTH, 16, trace FIFO entries; power of 2, >=2.
- TIMEOUT, 1024, max RUN cycles before timeout; >=2.
- HALT_REPEAT, 4, consecutive same-pc commits that declare halt; >=2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: clear all state, enter RUN.
- cm_valid  in  1  commit valid this cycle.
- cm_pc  in  XLEN  committed pc.
- cm_result  in  XLEN  committed ALU result.
- exp_sig  in  XLEN  expected signature.
- rd_en  in  1  pop head of trace FIFO.
- rd_pc  out  XLEN  head pc (show-ahead).
- rd_result  out  XLEN  head result (show-ahead).
- empty  out  1  FIFO empty.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: commit dropped because FIFO full.
- signature  out  XLEN  running signature.
- cycle_cnt  out  32  cycles spent in RUN.
- commit_cnt  out  32  commits accepted in RUN.
- state  out  2  IDLE=0, RUN=1, HALTED=2, TIMEOUT=3.
- done  out  1  state is HALTED or TIMEOUT.
- pass  out  1  state==HALTED and signature==exp_sig.

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n. Reset: state=IDLE; FIFO empty (count=0); overflow=0; signature=0; cycle_cnt=0; commit_cnt=0; rep_cnt=0; last_pc_valid=0. rd_pc/rd_result are don't-care while empty.
- start (any state, takes priority over all else): same clearing as reset, then state=RUN next cycle. A commit in the start cycle is ignored.
- RUN: cycle_cnt +1 per cycle, saturating at 2^32-1. Each cm_valid cycle, commit_cnt +1, signature <= rotl1(signature) ^ cm_pc ^ cm_result, and the entry is written to the FIFO if space exists.
- Commits outside RUN are ignored entirely.
- FIFO write when full and no same-cycle pop: entry dropped, overflow<=1 (sticky until start or reset); signature and commit_cnt still update.
- FIFO full with same-cycle pop and write: both occur; count unchanged; no overflow.
- rd_en while empty: ignored. Pop and write while empty: write takes effect, pop ignored.
- Pointers wrap modulo DEPTH. count updates one cycle after the write/pop edge.
- Halt detect, on a RUN commit:
  - last_pc_valid and cm_pc==last_pc: rep_cnt+1.
  - Otherwise: rep_cnt<=1.
  - Always: last_pc<=cm_pc, last_pc_valid<=1.
  - The commit that makes rep_cnt reach HALT_REPEAT moves state to HALTED next cycle; that commit is logged and signed.
- Timeout: in RUN, when cycle_cnt==TIMEOUT-1 at the clock edge, state goes to TIMEOUT.
- Halt and timeout in the same cycle: HALTED wins.
- HALTED/TIMEOUT: counters and signature frozen; FIFO remains readable; leave only via start or reset.
- pass and done are combinational from the registered state and signature.
- Reset asserted mid-RUN: immediate return to IDLE with all contents lost.

Decomposition:
- Shared package riscv_tb_pkg: monitor state enum (IDLE/RUN/HALTED/TIMEOUT) and rotl1 signature function.
- One sub-module, trace_fifo: parametrised WIDTH/DEPTH, show-ahead synchronous FIFO with full/empty/count, asynchronous active-low reset on pointers.
- Monitor top instantiates trace_fifo with WIDTH=2*XLEN.

Test Plan:
- Reset then start; commits pc=0,4,8 with results 5,7,12 -> commit_cnt=3, count=3; pops return (0,5),(4,7),(8,12) in order, then empty=1.
- Signature: single commit pc=0x4, result=0x1 after start -> signature=0x00000005. A second commit pc=0x8, result=0x2 -> 0x00000000 (rotl of 5 is 0xA, xor 8 xor 2).
- Halt: commits at pc=0x10 four consecutive times (HALT_REPEAT=4) -> state=HALTED the cycle after the 4th; done=1; pass=1 only when exp_sig matches the signature; later commits do not change commit_cnt.
- Timeout: start with no commits and TIMEOUT=1024 -> state=TIMEOUT after exactly 1024 RUN cycles; cycle_cnt=1023 frozen; pass=0.
- Overflow: DEPTH=16, 17 commits with no pops -> count=16, overflow=1, commit_cnt=17. Repeat with a simultaneous pop on the 17th commit -> overflow=0, count=16.
- Reset mid-RUN after 5 commits -> state=IDLE, empty=1, counters 0. A following start begins a fresh run.
